axi_stream_strip_header: RTL

// - Downstream counterpart of the header-insert stage. Removes the first S bytes (S = strip_cnt, sampled per packet) from each AXI-Stream packet.
// - Emits those S bytes on a header side channel.
// - Forwards the remaining payload re-packed so every beat is high-byte aligned.
// - Byte order: byte 0 = data[DATA_WD-1 -: 8] = keep[DATA_BYTE_WD-1].

---
 rtl/axis_pkg.sv | 40 ++++
 rtl/axis_byte_merger.sv | 32 +++
 rtl/axi_stream_strip_header.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: default widths, FSM encoding and keep helpers.
package axis_pkg;

    localparam int AXIS_DATA_WD      = 32;
    localparam int AXIS_DATA_BYTE_WD = AXIS_DATA_WD / 8;
    // Helpers work on a wide keep vector; callers truncate to their own width.
    localparam int KEEP_MAX          = 128;

    localparam logic [1:0] ST_FIRST = 2'd0;
    localparam logic [1:0] ST_BODY  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // n high bits of an nb-bit keep set
    function automatic logic [KEEP_MAX-1:0] keep_hi(input int n, input int nb);
        logic [KEEP_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < KEEP_MAX; i++)
            r[i] = (i < nb) && (i >= nb - n);
        return r;
    endfunction

    // n low bits set
    function automatic logic [KEEP_MAX-1:0] keep_lo(input int n);
        logic [KEEP_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < KEEP_MAX; i++)
            r[i] = (i < n);
        return r;
    endfunction

    // number of enabled bytes
    function automatic int popcount(input logic [KEEP_MAX-1:0] k);
        int c;
        c = 0;
        for (int i = 0; i < KEEP_MAX; i++)
            c += int'(k[i]);
        return c;
    endfunction

endpackage

// File: rtl/axis_byte_merger.sv
// Combinational byte merger: appends an input beat behind a left-aligned residue
// of res_cnt bytes, giving the outgoing word and the bytes left over.
module axis_byte_merger
    import axis_pkg::*;
#(
    parameter int DATA_WD      = AXIS_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic [DATA_WD-1:0]      res_data,
    input  logic [CNT_WD-1:0]       res_cnt,
    input  logic [DATA_WD-1:0]      in_data,
    input  logic [DATA_BYTE_WD-1:0] in_keep,
    output logic [DATA_WD-1:0]      out_data,
    output logic [DATA_WD-1:0]      new_res,
    output logic [CNT_WD-1:0]       in_cnt,
    output logic [CNT_WD:0]         total
);

    logic [2*DATA_WD-1:0] cat;

    // residue occupies the top res_cnt bytes; the input slides in right behind it
    always_comb begin
        cat      = {res_data, {DATA_WD{1'b0}}}
                 | ({in_data, {DATA_WD{1'b0}}} >> {res_cnt, 3'b000});
        out_data = cat[2*DATA_WD-1 -: DATA_WD];
        new_res  = cat[DATA_WD-1:0];
        in_cnt   = CNT_WD'(popcount(KEEP_MAX'(in_keep)));
        total    = {1'b0, res_cnt} + {1'b0, in_cnt};
    end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips the first strip_cnt bytes of each packet onto a header side channel and
// forwards the rest of the packet re-packed to high-aligned beats.
module axi_stream_strip_header
    import axis_pkg::*;
#(
    parameter int DATA_WD      = AXIS_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic [BYTE_CNT_WD-1:0]  strip_cnt,
    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
    input  logic                    ready_hdr,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
);

    localparam int CNT_WD = BYTE_CNT_WD + 1;
    localparam logic [CNT_WD-1:0] NB = CNT_WD'(DATA_BYTE_WD);

    logic [1:0]          state;
    logic [DATA_WD-1:0]  res_data;
    logic [CNT_WD-1:0]   res_cnt;

    logic [DATA_WD-1:0]  din_m;
    logic [DATA_WD-1:0]  m_out;
    logic [DATA_WD-1:0]  m_res;
    logic [CNT_WD-1:0]   m_in_cnt;
    logic [CNT_WD:0]     m_total;
    logic [CNT_WD-1:0]   s_ext;
    logic [CNT_WD-1:0]   first_cnt;
    logic [DATA_WD-1:0]  first_res;
    logic [DATA_WD-1:0]  hdr_word;
    logic                out_free;
    logic                hdr_free;
    logic                acc;
    logic                body_ovf;

    // disabled bytes are zeroed so short beats never drag stale data along
    for (genvar b = 0; b < DATA_BYTE_WD; b++) begin : g_mask
        assign din_m[8*b +: 8] = keep_in[b] ? data_in[8*b +: 8] : 8'h00;
    end

    axis_byte_merger #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .CNT_WD       (CNT_WD)
    ) u_merger (
        .res_data (res_data),
        .res_cnt  (res_cnt),
        .in_data  (din_m),
        .in_keep  (keep_in),
        .out_data (m_out),
        .new_res  (m_res),
        .in_cnt   (m_in_cnt),
        .total    (m_total)
    );

    assign out_free  = !valid_out || ready_out;
    assign hdr_free  = !valid_hdr || ready_hdr;
    // first beats also need the header slot, since they may load it
    assign ready_in  = (state != ST_FLUSH) && out_free && (state != ST_FIRST || hdr_free);
    assign acc       = valid_in && ready_in;
    assign s_ext     = {1'b0, strip_cnt};
    // clamp keeps an oversized strip count from wrapping the residue count
    assign first_cnt = (m_in_cnt > s_ext) ? m_in_cnt - s_ext : '0;
    assign first_res = din_m << {s_ext, 3'b000};
    assign hdr_word  = data_in >> {NB - s_ext, 3'b000};
    assign body_ovf  = m_total > {1'b0, NB};

    // packet FSM, residue register and the payload/header output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FIRST;
            res_data  <= '0;
            res_cnt   <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
            valid_hdr <= 1'b0;
            data_hdr  <= '0;
            keep_hdr  <= '0;
        end else begin
            if (ready_out) valid_out <= 1'b0;
            if (ready_hdr) valid_hdr <= 1'b0;
            case (state)
                ST_FIRST: if (acc) begin
                    if (s_ext != '0) begin
                        valid_hdr <= 1'b1;
                        data_hdr  <= hdr_word;
                        keep_hdr  <= DATA_BYTE_WD'(keep_lo(int'(s_ext)));
                    end
                    if (last_in) begin
                        // single-beat packet: whatever survives the strip goes out now
                        if (first_cnt != '0) begin
                            valid_out <= 1'b1;
                            data_out  <= first_res;
                            keep_out  <= DATA_BYTE_WD'(keep_hi(int'(first_cnt), DATA_BYTE_WD));
                            last_out  <= 1'b1;
                        end
                    end else begin
                        res_data <= first_res;
                        res_cnt  <= first_cnt;
                        state    <= ST_BODY;
                    end
                end
                ST_BODY: if (acc) begin
                    valid_out <= 1'b1;
                    data_out  <= m_out;
                    res_data  <= m_res;
                    res_cnt   <= CNT_WD'(m_total - {1'b0, NB});
                    if (last_in && !body_ovf) begin
                        keep_out <= DATA_BYTE_WD'(keep_hi(int'(m_total), DATA_BYTE_WD));
                        last_out <= 1'b1;
                        state    <= ST_FIRST;
                    end else begin
                        keep_out <= '1;
                        last_out <= 1'b0;
                        state    <= last_in ? ST_FLUSH : ST_BODY;
                    end
                end
                ST_FLUSH: if (out_free) begin
                    valid_out <= 1'b1;
                    data_out  <= res_data;
                    keep_out  <= DATA_BYTE_WD'(keep_hi(int'(res_cnt), DATA_BYTE_WD));
                    last_out  <= 1'b1;
                    state     <= ST_FIRST;
                end
                default: state <= ST_FIRST;
            endcase
        end
    end

endmodule
